// File: rtl/lfsr12_core.sv
// lfsr12_core: 12-bit maximal-length Fibonacci LFSR (x^12+x^6+x^4+x+1) with seed load, enable, period tracking and lock-up recovery
//   clk, reset      : clock, synchronous active-high reset
//   en, load        : advance one step / load seed_in (load wins over en)
//   seed_in         : seed for load; zero is replaced by 12'h001 with a lockup pulse
//   q, serial_out   : registered state word, serial bit q[11]
//   step_cnt        : enabled steps since last reset/load, wraps to 0 when the seed recurs
//   period_done     : one-cycle pulse when the state returns to the active seed
//   lockup          : one-cycle pulse when an all-zero state or seed was replaced
module lfsr12_core #(
    parameter int               WIDTH      = 12,
    parameter logic [WIDTH-1:0] RESET_SEED = 12'h001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);
    typedef enum logic {RUN, RECOVER} state_t;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, seed_q, seed_d, cnt_q, cnt_d, nxt;
    logic             pd_q, pd_d, lk_q, lk_d, fb;
    assign fb  = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
    assign nxt = {lfsr_q[WIDTH-2:0], fb};
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        pd_d    = 1'b0;
        lk_d    = 1'b0;
        if (state_q == RECOVER) begin
            lfsr_d  = seed_q;
            cnt_d   = '0;
            lk_d    = 1'b1;
            state_d = RUN;
        end else if (lfsr_q == '0) begin
            // all-zero is a dead state of the LFSR; freeze this edge and restore the seed on the next
            state_d = RECOVER;
        end else if (load) begin
            lfsr_d = (seed_in == '0) ? ONE : seed_in;
            seed_d = (seed_in == '0) ? ONE : seed_in;
            lk_d   = (seed_in == '0);
            cnt_d  = '0;
        end else if (en) begin
            lfsr_d = nxt;
            pd_d   = (nxt == seed_q);
            cnt_d  = (nxt == seed_q) ? '0 : cnt_q + WIDTH'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            lfsr_q  <= RESET_SEED;
            seed_q  <= RESET_SEED;
            cnt_q   <= '0;
            pd_q    <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            pd_q    <= pd_d;
            lk_q    <= lk_d;
        end
    end
    assign q           = lfsr_q;
    assign serial_out  = lfsr_q[WIDTH-1];
    assign step_cnt    = cnt_q;
    assign period_done = pd_q;
    assign lockup      = lk_q;
endmodule

// File: doc/lfsr12_core.md
Name: lfsr12_core

Overview:
- 12-bit maximal-length Fibonacci LFSR: a register of D flip-flop stages with synchronous reset, closed through an XOR feedback network.
- Sits directly above the single D flip-flop stage. Owns the shift register, the feedback, seed loading, enable gating and period tracking.
- Outputs a parallel state word and a serial bit for downstream pattern consumers.
- Includes a small control FSM that detects and recovers from the all-zero lock-up state.

Parameters:
- WIDTH, 12, register width; taps below are defined for 12 only.
- RESET_SEED, 12'h001, state loaded on reset; must be nonzero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance the LFSR one step per cycle while high.
- load  input  1  load seed_in on this edge.
- seed_in  input  12  seed value used with load.
- q  output  12  current LFSR state.
- serial_out  output  1  equals q[11].
- step_cnt  output  12  number of enabled steps since the last reset or load.
- period_done  output  1  one-cycle pulse when the state returns to the active seed.
- lockup  output  1  one-cycle pulse when an all-zero state was detected and replaced.

Behaviour:
- Polynomial is x^12+x^6+x^4+x+1.
- Feedback: fb = q[11]^q[5]^q[3]^q[0].
- Next state: {q[10:0], fb}.
- Period is 4095; the all-zero state is excluded.

Reset (reset=1 at a rising edge):
- q=RESET_SEED; active seed register = RESET_SEED.
- step_cnt=0, period_done=0, lockup=0, FSM=RUN.
- Reset overrides load and en.

Priority per edge: reset > load > en > hold.

Load (load=1):
- If seed_in != 0: q=seed_in, active seed = seed_in.
- If seed_in == 0: q=12'h001, active seed = 12'h001, lockup pulses 1 for one cycle.
- step_cnt=0; period_done=0.
- en is ignored on the same edge.

Enabled step (en=1, no load):
- q advances one step and step_cnt increments.
- When the next state equals the active seed: step_cnt wraps to 0 and period_done=1 on that same edge, registered so it is visible for one cycle.
- For a maximal seed this occurs exactly every 4095 steps.

Hold (en=0): q and step_cnt hold; period_done and lockup are 0.

FSM, two states: RUN and RECOVER.
- RUN: normal operation.
- If q==0 is observed at a clock edge in RUN (only possible through an external fault or X cleanup), next state is RECOVER; the q update on that edge is suppressed.
- RECOVER: on the next edge, q=active seed, step_cnt=0, lockup pulses 1, return to RUN. en and load are ignored during this cycle; reset still applies.

General rules:
- Outputs are registered; latency from en to the new q is 1 cycle.
- serial_out is combinational from q[11].
- step_cnt is unsigned 12-bit; it never exceeds 4094 for a maximal sequence.
- Reset asserted mid-sequence takes effect at the next edge regardless of FSM state.

Test Plan:
- Reset for 2 cycles, then en=1 for 4 cycles -> q sequence 001, 003, 007, 00F, 01E; step_cnt 0,1,2,3,4; serial_out=0 throughout.
- Reset, then en=1 for 4095 cycles -> period_done=1 on exactly the 4095th step with q=001 and step_cnt=0; no earlier pulse; no state repeats before that.
- load=1 with seed_in=12'hA5C, then en for 4095 cycles -> first q=A5C; period_done at step 4095 with q=A5C.
- load=1 with seed_in=0 -> q=001, lockup=1 for one cycle, step_cnt=0.
- en toggled 1,0,0,1 from reset -> q 003, 003, 003, 007; step_cnt 1,1,1,2.
- Mid-run, 10 steps in: reset=1 with load=1 and en=1 on the same edge -> q=001, step_cnt=0, no period_done.
